// File: rtl/fir_param.sv
// Streaming signed direct-form FIR: stage 1 registers per-tap products, stage 2 sums,
// rounds half-up, scales by FRAC and saturates to OUT_W. Coefficients are runtime-writable.
module fir_param #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 8,
  parameter int TAPS   = 8,
  parameter int FRAC   = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic signed [IN_W-1:0]      in_data,
  input  logic                        coef_we,
  input  logic [$clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]    coef_data,
  output logic                        out_valid,
  output logic signed [OUT_W-1:0]     out_data,
  output logic                        sat
);

  localparam int AW    = $clog2(TAPS);
  localparam int PW    = IN_W + COEF_W;
  localparam int ACC_W = IN_W + COEF_W + $clog2(TAPS);
  localparam longint RND = (longint'(1) << FRAC) >> 1;
  localparam logic signed [ACC_W-1:0]  OUT_MAX  = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0]  OUT_MIN  = -OUT_MAX - 1;
  localparam logic signed [COEF_W-1:0] COEF_RST = COEF_W'(longint'(1) << FRAC);

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a + ACC_W'(RND);
    return r >>> FRAC;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > OUT_MAX)      return {1'b1, OUT_MAX[OUT_W-1:0]};
    else if (a < OUT_MIN) return {1'b1, OUT_MIN[OUT_W-1:0]};
    else                  return {1'b0, a[OUT_W-1:0]};
  endfunction

  logic signed [COEF_W-1:0] coef_q    [TAPS];
  logic signed [COEF_W-1:0] coef_d    [TAPS];
  logic signed [IN_W-1:0]   delay_q   [TAPS-1];
  logic signed [IN_W-1:0]   delay_d   [TAPS-1];
  logic signed [PW-1:0]     prod_p1_q [TAPS];
  logic signed [PW-1:0]     prod_p1_d [TAPS];
  logic                     vld_p1_q, vld_p1_d;
  logic                     vld_p2_q, vld_p2_d;
  logic signed [OUT_W-1:0]  data_p2_q, data_p2_d;
  logic                     sat_p2_q, sat_p2_d;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  scaled;
  logic [OUT_W:0]           sat_res;

  always_comb begin
    coef_d = coef_q;
    if (coef_we && ({1'b0, coef_addr} < (AW + 1)'(TAPS))) coef_d[coef_addr] = coef_data;

    // Stage 1: products and delay-line shift on accept
    delay_d   = delay_q;
    prod_p1_d = prod_p1_q;
    vld_p1_d  = 1'b0;
    if (clr) begin
      delay_d = '{default: '0};
    end else if (in_valid) begin
      vld_p1_d     = 1'b1;
      prod_p1_d[0] = PW'(in_data) * PW'(coef_q[0]);
      for (int k = 1; k < TAPS; k++) prod_p1_d[k] = PW'(delay_q[k-1]) * PW'(coef_q[k]);
      delay_d[0] = in_data;
      for (int k = 1; k < TAPS - 1; k++) delay_d[k] = delay_q[k-1];
    end

    // Stage 2: accumulate, round, scale, saturate
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod_p1_q[k]);
    scaled    = round_shift(acc);
    sat_res   = saturate(scaled);
    vld_p2_d  = vld_p1_q;
    data_p2_d = vld_p1_q ? $signed(sat_res[OUT_W-1:0]) : data_p2_q;
    sat_p2_d  = vld_p1_q & sat_res[OUT_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coef_q    <= '{default: '0};
      coef_q[0] <= COEF_RST;
      delay_q   <= '{default: '0};
      prod_p1_q <= '{default: '0};
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      sat_p2_q  <= 1'b0;
    end else begin
      coef_q    <= coef_d;
      delay_q   <= delay_d;
      prod_p1_q <= prod_p1_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      sat_p2_q  <= sat_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign sat       = sat_p2_q;

endmodule

// File: tb/tb_fir_param.sv
// Directed bench for fir_param with default parameters (8-bit, 8 taps, FRAC=6).
module tb_fir_param;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_data = '0;
  logic              coef_we = 1'b0;
  logic [2:0]        coef_addr = '0;
  logic signed [7:0] coef_data = '0;
  logic              out_valid;
  logic signed [7:0] out_data;
  logic              sat;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [7:0] q_data[$];
  logic              q_sat[$];

  fir_param dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_data(out_data), .sat(sat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      q_data.push_back(out_data);
      q_sat.push_back(sat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [7:0] x);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wr_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 8'(val);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic flush();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    q_data.delete();
    q_sat.delete();
  endtask

  task automatic avg_setup();
    for (int k = 0; k < 8; k++) wr_coef(k, (k < 4) ? 16 : 0);
    flush();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_cmp++;
    if (out_data !== 8'sd0) begin n_err++; $display("FAIL reset_data got %0d want 0", out_data); end
    n_cmp++;
    if (sat !== 1'b0) begin n_err++; $display("FAIL reset_sat got %0b want 0", sat); end
  endtask

  task automatic test_latency();
    in_valid = 1'b1;
    in_data  = 8'sd5;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early got %0b want 0", out_valid); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'sd5)
      begin n_err++; $display("FAIL lat_out got v=%0b d=%0d want v=1 d=5", out_valid, out_data); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'sd5)
      begin n_err++; $display("FAIL lat_hold got v=%0b d=%0d want v=0 d=5", out_valid, out_data); end
    q_data.delete();
    q_sat.delete();
  endtask

  task automatic test_passthrough();
    for (int i = 0; i <= 12; i++) send(8'(i * 10));
    tick(); tick(); tick();
    n_cmp++;
    if (q_data.size() != 13) begin n_err++; $display("FAIL pt_count got %0d want 13", q_data.size()); end
    for (int i = 0; i < 13 && i < q_data.size(); i++) begin
      n_cmp++;
      if (q_data[i] !== 8'(i * 10) || q_sat[i] !== 1'b0)
        begin n_err++; $display("FAIL pt_%0d got %0d sat %0b want %0d sat 0", i, q_data[i], q_sat[i], i * 10); end
    end
  endtask

  task automatic test_average();
    logic signed [7:0] exp_v[6] = '{10, 20, 30, 40, 40, 40};
    avg_setup();
    for (int i = 0; i < 6; i++) send(8'sd40);
    tick(); tick(); tick();
    n_cmp++;
    if (q_data.size() != 6) begin n_err++; $display("FAIL avg_count got %0d want 6", q_data.size()); end
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      n_cmp++;
      if (q_data[i] !== exp_v[i]) begin n_err++; $display("FAIL avg_%0d got %0d want %0d", i, q_data[i], exp_v[i]); end
    end
  endtask

  task automatic test_coef_same_edge();
    flush();
    in_valid  = 1'b1;
    in_data   = 8'sd40;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'sd64;
    tick();
    coef_we = 1'b0;
    send(8'sd40);
    tick(); tick(); tick();
    n_cmp++;
    if (q_data.size() != 2) begin n_err++; $display("FAIL same_count got %0d want 2", q_data.size()); end
    else begin
      n_cmp++;
      if (q_data[0] !== 8'sd10) begin n_err++; $display("FAIL same_old got %0d want 10", q_data[0]); end
      n_cmp++;
      if (q_data[1] !== 8'sd50) begin n_err++; $display("FAIL same_new got %0d want 50", q_data[1]); end
    end
  endtask

  task automatic test_saturation();
    logic signed [7:0] xin[3]   = '{100, -100, 20};
    logic signed [7:0] exp_v[3] = '{127, -128, 40};
    logic              exp_s[3] = '{1'b1, 1'b1, 1'b0};
    wr_coef(0, 127);
    for (int k = 1; k < 8; k++) wr_coef(k, 0);
    flush();
    for (int i = 0; i < 3; i++) send(xin[i]);
    tick(); tick(); tick();
    n_cmp++;
    if (q_data.size() != 3) begin n_err++; $display("FAIL sat_count got %0d want 3", q_data.size()); end
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      n_cmp++;
      if (q_data[i] !== exp_v[i] || q_sat[i] !== exp_s[i])
        begin n_err++; $display("FAIL sat_%0d got %0d sat %0b want %0d sat %0b", i, q_data[i], q_sat[i], exp_v[i], exp_s[i]); end
    end
  endtask

  task automatic test_rounding();
    logic signed [7:0] xin[4]   = '{3, -3, 4, -5};
    logic signed [7:0] exp_v[4] = '{2, -1, 2, -2};
    wr_coef(0, 32);
    flush();
    for (int i = 0; i < 4; i++) send(xin[i]);
    tick(); tick(); tick();
    n_cmp++;
    if (q_data.size() != 4) begin n_err++; $display("FAIL rnd_count got %0d want 4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_cmp++;
      if (q_data[i] !== exp_v[i]) begin n_err++; $display("FAIL rnd_%0d got %0d want %0d", i, q_data[i], exp_v[i]); end
    end
  endtask

  task automatic test_valid_gaps();
    int idle_valid = 0;
    for (int k = 0; k < 8; k++) wr_coef(k, k + 1);
    flush();
    for (int i = 0; i < 10; i++) begin
      send((i == 0) ? 8'sd64 : 8'sd0);
      tick();
    end
    tick(); tick(); tick();
    n_cmp++;
    if (q_data.size() != 10) begin n_err++; $display("FAIL gap_count got %0d want 10", q_data.size()); end
    for (int i = 0; i < 10 && i < q_data.size(); i++) begin
      n_cmp++;
      if (q_data[i] !== ((i < 8) ? 8'(i + 1) : 8'sd0))
        begin n_err++; $display("FAIL gap_%0d got %0d want %0d", i, q_data[i], (i < 8) ? i + 1 : 0); end
    end
  endtask

  task automatic test_flush_stream();
    logic signed [7:0] exp_v[11] = '{10, 20, 30, 40, 40, 40, 40, 10, 20, 30, 40};
    avg_setup();
    for (int i = 0; i < 7; i++) send(8'sd40);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'sd40;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send(8'sd40);
    tick(); tick(); tick();
    n_cmp++;
    if (q_data.size() != 11) begin n_err++; $display("FAIL flush_count got %0d want 11", q_data.size()); end
    for (int i = 0; i < 11 && i < q_data.size(); i++) begin
      n_cmp++;
      if (q_data[i] !== exp_v[i]) begin n_err++; $display("FAIL flush_%0d got %0d want %0d", i, q_data[i], exp_v[i]); end
    end
  endtask

  task automatic test_midstream_reset();
    avg_setup();
    send(8'sd40);
    send(8'sd40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_data.delete();
    q_sat.delete();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'sd0)
      begin n_err++; $display("FAIL mrst_state got v=%0b d=%0d want v=0 d=0", out_valid, out_data); end
    tick(); tick(); tick();
    n_cmp++;
    if (q_data.size() != 0) begin n_err++; $display("FAIL mrst_silent got %0d outputs want 0", q_data.size()); end
    send(8'sd100);
    send(8'sd7);
    tick(); tick(); tick();
    n_cmp++;
    if (q_data.size() != 2) begin n_err++; $display("FAIL mrst_count got %0d want 2", q_data.size()); end
    else begin
      n_cmp++;
      if (q_data[0] !== 8'sd100 || q_data[1] !== 8'sd7)
        begin n_err++; $display("FAIL mrst_pass got %0d,%0d want 100,7", q_data[0], q_data[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_passthrough();
    test_average();
    test_coef_same_edge();
    test_saturation();
    test_rounding();
    test_valid_gaps();
    test_flush_stream();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_param.md
Name: fir_param

Overview:
- Parametrised, streaming, signed direct-form FIR filter; successor to the fixed 8-bit fir block in the Lab08 datapath.
- Configurable data, coefficient and output widths and tap count.
- Adds a valid handshake, runtime-loadable coefficients, round-half-up scaling, output saturation with a flag, and a synchronous delay-line flush.
- Sits between the sample source and the downstream DSP stage; one sample per clock maximum.

Parameters:
- IN_W, 8, input sample width (signed two's complement)
- COEF_W, 8, coefficient width (signed)
- OUT_W, 8, output sample width (signed)
- TAPS, 8, number of taps (>=2)
- FRAC, 6, coefficient fractional bits; result is shifted right by FRAC (FRAC < COEF_W-1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- clr  in  1  synchronous flush of delay line and pipeline; coefficients kept
- in_valid  in  1  in_data is accepted on this edge
- in_data  in  IN_W  input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  tap index k (coefficient h[k])
- coef_data  in  COEF_W  coefficient value
- out_valid  out  1  out_data valid, one-cycle pulse per accepted sample
- out_data  out  OUT_W  filtered sample
- sat  out  1  out_data was clipped; meaningful only with out_valid

Behaviour:
- Reset (rst=1 at edge):
  - delay line, product registers, out_data, out_valid and sat all cleared to 0.
  - coef[0] = 1<<FRAC; all other coef = 0, so the filter resets to passthrough.
- Priority: rst > clr > in_valid. coef_we is independent of clr and is blocked only by rst.
- Accept edge (in_valid=1, clr=0):
  - product register k captures x[n-k]*coef[k], where x[n]=in_data and x[n-k]=delay[k-1].
  - Coefficients used are the register values before this edge.
  - Delay line shifts in in_data. Stage-1 valid is set.
- When in_valid=0: delay line and products hold; stage-1 valid cleared.
- Stage 2, the edge after accept:
  - sum all products at full precision, ACC_W = IN_W+COEF_W+clog2(TAPS).
  - add 1<<(FRAC-1) (skipped when FRAC=0), then arithmetic shift right FRAC.
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - register out_data, sat and out_valid=1.
- Latency: in_valid sampled at edge k produces out_valid high for the cycle following edge k+1. Throughput is 1 sample/clk.
- out_data holds its last value when out_valid=0. sat is 0 whenever out_valid=0.
- Coefficient write: coef[coef_addr] <= coef_data at the edge.
  - Takes effect for samples accepted on later edges.
  - A write on the same edge as an accept does not affect that sample.
  - coef_addr >= TAPS is ignored.
- clr=1:
  - delay line zeroed and stage-1 valid cleared.
  - A concurrent in_valid sample is discarded.
  - The stage-2 result already in flight (accepted on the previous edge) still emits normally.
- rst mid-stream: in-flight samples are lost; no out_valid on the following edges until a new accept occurs.
- No backpressure: the downstream block must accept every out_valid pulse.

Test Plan:
- Passthrough after reset: rst 2 cycles, then in_data 0,10,20,...,120 with in_valid every cycle -> out_data 0,10,...,120, each 2 edges after its accept; sat=0 throughout.
- 4-tap average:
  - write coef[0..3]=16 and coef[4..7]=0, then clr.
  - constant input 40 -> out_data 10,20,30,40,40,...
  - coef write on the same edge as the first accept -> that sample uses the old coefficient.
- Saturation:
  - coef[0]=127, others 0.
  - input 100 -> out_data 127, sat=1.
  - input -100 -> out_data -128, sat=1.
  - input 20 -> 40, sat=0.
- Rounding:
  - coef[0]=32 (0.5).
  - input 3 -> 2; input -3 -> -1; input 4 -> 2; input -5 -> -2 (round half up).
- Valid gaps:
  - coef[k]=k+1.
  - impulse 64 followed by zeros, with in_valid asserted on alternating cycles -> out_data 1,2,...,8 then 0s, one per accepted sample.
  - out_valid is never asserted for idle cycles.
- Flush and mid-stream reset:
  - clr during a steady 40 stream in the average setup -> the in-flight output still emits; the next outputs restart at 10,20,30,40.
  - clr concurrent with in_valid drops that sample.
  - rst mid-stream -> outputs silent until a new accept, coefficients back to passthrough.
